// File: rtl/cache_fill_fsm.sv
// Block-fill sequencer for a direct cache miss: issues eight word reads for the
// missing 16-byte block, writes each returned word into the data array and finishes with one tag write.
module cache_fill_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        mem_grant,
  input  logic        memory_data_valid,
  input  logic [15:0] memory_data,
  output logic        fsm_busy,
  output logic        mem_ren,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        write_tag_array
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  req_cnt;
  logic [3:0]  req_cnt_nxt;
  logic [2:0]  rsp_cnt;
  logic [2:0]  rsp_cnt_nxt;
  logic [15:0] base;
  logic [15:0] base_nxt;
  logic        req_open;

  // req_cnt[3] set means all eight requests have been accepted
  assign req_open = (state == FILL) && !req_cnt[3];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req_cnt <= 4'd0;
      rsp_cnt <= 3'd0;
      base    <= 16'h0000;
    end else begin
      state   <= state_nxt;
      req_cnt <= req_cnt_nxt;
      rsp_cnt <= rsp_cnt_nxt;
      base    <= base_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt   = state;
    req_cnt_nxt = req_cnt;
    rsp_cnt_nxt = rsp_cnt;
    base_nxt    = base;
    case (state)
      IDLE: begin
        if (miss_detected) begin
          base_nxt    = miss_address & 16'hFFF0;
          req_cnt_nxt = 4'd0;
          rsp_cnt_nxt = 3'd0;
          state_nxt   = FILL;
        end
      end
      FILL: begin
        if (req_open && mem_grant) begin
          req_cnt_nxt = req_cnt + 4'd1;
        end
        // Responses arrive strictly in request order, so a running count names the word
        if (memory_data_valid) begin
          rsp_cnt_nxt = rsp_cnt + 3'd1;
          if (rsp_cnt == 3'd7) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    fsm_busy         = 1'b0;
    mem_ren          = 1'b0;
    memory_address   = base;
    write_data_array = 1'b0;
    fill_word        = 3'd0;
    fill_data        = 16'h0000;
    write_tag_array  = 1'b0;
    case (state)
      IDLE: begin
        fsm_busy = miss_detected;
      end
      FILL: begin
        fsm_busy         = 1'b1;
        mem_ren          = req_open;
        // Word offset replaces the zero low nibble, so the address never leaves the block
        if (req_open) begin
          memory_address = {base[15:4], req_cnt[2:0], 1'b0};
        end
        write_data_array = memory_data_valid;
        fill_word        = rsp_cnt;
        fill_data        = memory_data;
        write_tag_array  = memory_data_valid && (rsp_cnt == 3'd7);
      end
      default: fsm_busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a 4-cycle in-order memory plus a
// transaction-level model of the fill (block base, requests issued, words returned).
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        mem_grant;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_ren;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        write_tag_array;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .mem_grant         (mem_grant),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_ren           (mem_ren),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .fill_word         (fill_word),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array)
  );

  typedef struct {
    int          due;
    logic [15:0] addr;
    logic [15:0] data;
  } rsp_t;

  rsp_t        pend[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  // Reference model of the fill transaction
  bit          m_known = 1'b0;
  bit          m_busy = 1'b0;
  logic [15:0] m_base = 16'h0000;
  int          m_issued = 0;
  int          m_returned = 0;

  bit          spurious = 1'b0;
  int          rc, tag_cyc, last_req_cyc, wda_cnt, tag_cnt, ren_cnt, busy_gap;
  logic [15:0] min_addr, max_addr;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    rc = 0; tag_cyc = -1; last_req_cyc = -1; wda_cnt = 0; tag_cnt = 0;
    ren_cnt = 0; busy_gap = 0; min_addr = 16'hFFFF; max_addr = 16'h0000;
  endtask

  task automatic step(input bit miss, input logic [15:0] maddr, input bit grant, input bit r);
    bit          e_ren, e_wda, req_acc;
    logic [15:0] e_addr, rsp_addr, req_addr;
    miss_detected     = miss;
    miss_address      = maddr;
    mem_grant         = grant;
    rst               = r;
    memory_data       = 16'($urandom);
    memory_data_valid = 1'b0;
    rsp_addr          = 16'h0000;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      memory_data_valid = 1'b1;
      memory_data       = pend[0].data;
      rsp_addr          = pend[0].addr;
      void'(pend.pop_front());
    end else if (spurious && !m_busy) begin
      memory_data_valid = 1'b1;
    end
    @(negedge clk);
    if (m_known) begin
      e_ren  = m_busy && (m_issued < 8);
      e_addr = e_ren ? m_base + 16'(2 * m_issued) : m_base;
      e_wda  = m_busy && memory_data_valid;
      chk("fsm_busy", 16'(fsm_busy), 16'(m_busy || miss));
      chk("mem_ren", 16'(mem_ren), 16'(e_ren));
      chk("memory_address", memory_address, e_addr);
      chk("write_data_array", 16'(write_data_array), 16'(e_wda));
      chk("fill_word", 16'(fill_word), m_busy ? 16'(m_returned) : 16'h0000);
      chk("fill_data", fill_data, m_busy ? memory_data : 16'h0000);
      chk("write_tag_array", 16'(write_tag_array), 16'(e_wda && (m_returned == 7)));
      if (e_wda) begin
        chk("fill_order", 16'(fill_word), (rsp_addr >> 1) & 16'h0007);
        chk("rsp_block", rsp_addr & 16'hFFF0, m_base);
      end
    end
    if (write_data_array === 1'b1) wda_cnt++;
    if (write_tag_array === 1'b1) begin tag_cnt++; tag_cyc = rc; end
    if (fsm_busy !== 1'b1) busy_gap++;
    if (mem_ren === 1'b1) begin
      ren_cnt++;
      last_req_cyc = rc;
      if (memory_address < min_addr) min_addr = memory_address;
      if (memory_address > max_addr) max_addr = memory_address;
    end
    req_acc  = (mem_ren === 1'b1) && grant;
    req_addr = memory_address;
    @(posedge clk);
    if (req_acc) pend.push_back('{due: cyc + 4, addr: req_addr, data: 16'($urandom)});
    if (r) begin
      m_known = 1'b1; m_busy = 1'b0; m_base = 16'h0000; m_issued = 0; m_returned = 0;
    end else if (m_known) begin
      if (!m_busy) begin
        if (miss) begin
          m_busy = 1'b1; m_base = maddr & 16'hFFF0; m_issued = 0; m_returned = 0;
        end
      end else begin
        if (m_issued < 8 && grant) m_issued++;
        if (memory_data_valid) begin
          m_returned++;
          if (m_returned == 8) m_busy = 1'b0;
        end
      end
    end
    cyc++;
    rc++;
    #1;
  endtask

  initial begin
    logic [15:0] ra;
    int          n;
    rst = 1'b0; miss_detected = 1'b0; miss_address = 16'h0000;
    mem_grant = 1'b0; memory_data_valid = 1'b0; memory_data = 16'h0000;
    @(posedge clk); #1;

    // Reset, then idle cycles exercising the post-reset zero state
    step(1'b0, 16'h0000, 1'b1, 1'b1);
    clear_stats();
    for (int i = 0; i < 2; i++) step(1'b0, 16'hABCD, 1'b1, 1'b0);
    chk("reset_idle_busy", 16'(busy_gap), 16'd2);

    // Basic fill, constant grant
    clear_stats();
    for (int i = 0; i < 14; i++) step(i == 0, 16'h1236, 1'b1, 1'b0);
    chk("t1_tag_cycle", 16'(tag_cyc), 16'd12);
    chk("t1_last_req", 16'(last_req_cyc), 16'd8);
    chk("t1_req_count", 16'(ren_cnt), 16'd8);
    chk("t1_data_writes", 16'(wda_cnt), 16'd8);
    chk("t1_tag_writes", 16'(tag_cnt), 16'd1);
    chk("t1_busy_low_cycles", 16'(busy_gap), 16'd1);

    // Grant withheld in cycles 2-3
    clear_stats();
    for (int i = 0; i < 16; i++) step(i == 0, 16'h1236, !(i == 2 || i == 3), 1'b0);
    chk("t2_last_req", 16'(last_req_cyc), 16'd10);
    chk("t2_tag_cycle", 16'(tag_cyc), 16'd14);
    chk("t2_data_writes", 16'(wda_cnt), 16'd8);

    // Top-of-memory block stays inside its block
    clear_stats();
    for (int i = 0; i < 14; i++) step(i == 0, 16'hFFFE, 1'b1, 1'b0);
    chk("t3_min_addr", min_addr, 16'hFFF0);
    chk("t3_max_addr", max_addr, 16'hFFFE);
    chk("t3_tag_writes", 16'(tag_cnt), 16'd1);

    // Miss pulses during the fill and stray data while idle
    clear_stats();
    for (int i = 0; i < 18; i++) begin
      spurious = (i >= 14);
      step(i == 0 || i == 3 || i == 7, (i == 0) ? 16'h0527 : 16'h7770, 1'b1, 1'b0);
    end
    spurious = 1'b0;
    chk("t4_data_writes", 16'(wda_cnt), 16'd8);
    chk("t4_tag_writes", 16'(tag_cnt), 16'd1);
    chk("t4_min_addr", min_addr, 16'h0520);

    // Reset after the third returned word, late responses ignored, then a clean fill
    clear_stats();
    for (int i = 0; i < 9; i++) step(i == 0, 16'h0900, 1'b1, i == 8);
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("t5_no_tag_after_reset", 16'(tag_cnt), 16'd0);
    chk("t5_writes_before_reset", 16'(wda_cnt), 16'd4);
    clear_stats();
    for (int i = 0; i < 14; i++) step(i == 0, 16'h0040, 1'b1, 1'b0);
    chk("t5_refill_min", min_addr, 16'h0040);
    chk("t5_refill_max", max_addr, 16'h004E);
    chk("t5_refill_tag", 16'(tag_cnt), 16'd1);

    // Back-to-back misses
    clear_stats();
    for (int i = 0; i < 26; i++)
      step(i == 0 || i == 13, (i == 0) ? 16'h0100 : 16'h0200, 1'b1, 1'b0);
    chk("t6_busy_gap", 16'(busy_gap), 16'd0);
    chk("t6_data_writes", 16'(wda_cnt), 16'd16);
    chk("t6_tag_writes", 16'(tag_cnt), 16'd2);
    chk("t6_max_addr", max_addr, 16'h020E);
    for (int i = 0; i < 2; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);

    // Randomised fills: random address, grant and stray misses
    for (int k = 0; k < 6; k++) begin
      clear_stats();
      ra = 16'($urandom);
      step(1'b1, ra, $urandom_range(0, 3) != 0, 1'b0);
      n = 0;
      while (m_busy && n < 100) begin
        step($urandom_range(0, 5) == 0, 16'($urandom), $urandom_range(0, 3) != 0, 1'b0);
        n++;
      end
      chk("rnd_tag_writes", 16'(tag_cnt), 16'd1);
      chk("rnd_data_writes", 16'(wda_cnt), 16'd8);
      for (int i = 0; i < $urandom_range(0, 2); i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 The block SHALL have no parameters; widths are fixed: 16-bit words, 8-word (16-byte) blocks.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 miss_detected  input  1  cache lookup missed this cycle; start a block fill.
REQ-005 miss_address  input  16  byte address of the missing access.
REQ-006 mem_grant  input  1  the memory arbiter has given this block the memory port this cycle.
REQ-007 memory_data_valid  input  1  memory4c returns one read word this cycle; the arbiter routes it only for this block's own requests.
REQ-008 memory_data  input  16  returned read word.
REQ-009 fsm_busy  output  1  fill in progress; the cache holds the pipeline stalled.
REQ-010 mem_ren  output  1  read request to memory.
REQ-011 memory_address  output  16  byte address of the current read request.
REQ-012 write_data_array  output  1  write fill_data into data-array word fill_word of the victim line.
REQ-013 fill_word  output  3  word index within the block for the current data-array write.
REQ-014 fill_data  output  16  word to write; equals memory_data.
REQ-015 write_tag_array  output  1  write the tag and valid bit for the filled line.

Function
REQ-016 The block SHALL implement two states, IDLE and FILL, a 4-bit request counter req_cnt (0..8), a 3-bit response counter rsp_cnt (0..7) and a 16-bit block base register base.
REQ-017 IDLE with miss_detected=1: latch base={miss_address[15:4],4'h0}, clear both counters, next state FILL.
REQ-018 fsm_busy SHALL be combinational: 1 when state=FILL, or when state=IDLE and miss_detected=1; otherwise 0.
REQ-019 FILL: mem_ren=1 while req_cnt<8, and 0 once req_cnt=8.
REQ-020 memory_address SHALL be base+{req_cnt[2:0],1'b0} while mem_ren=1, and base otherwise; the addition SHALL stay within the block (no carry into bits [15:4]).
REQ-021 req_cnt SHALL increment only in cycles where mem_ren=1 and mem_grant=1; when mem_grant=0 the same address is held and re-requested next cycle.
REQ-022 FILL with memory_data_valid=1: write_data_array=1, fill_word=rsp_cnt and fill_data=memory_data in the same cycle, then rsp_cnt increments.
REQ-023 Responses SHALL be taken in request order; the block SHALL not depend on the memory latency value (4 cycles for memory4c).
REQ-024 FILL with memory_data_valid=1 and rsp_cnt=7: write_tag_array=1 in that same cycle, next state IDLE, fsm_busy=0 from the next cycle.
REQ-025 write_tag_array SHALL be a single-cycle pulse, exactly once per fill.
REQ-026 miss_detected during FILL SHALL be ignored; miss_address SHALL be sampled only on the IDLE-to-FILL transition.
REQ-027 memory_data_valid while in IDLE SHALL be ignored; in that case write_data_array and write_tag_array stay 0.
REQ-028 A new miss presented in the cycle after write_tag_array SHALL start a new fill with no idle gap.
REQ-029 write_data_array, mem_ren and write_tag_array SHALL never be asserted in IDLE.

Reset
REQ-030 With rst=1 at a clock edge, the block SHALL go to IDLE and clear req_cnt, rsp_cnt and base to 0.
REQ-031 From the cycle after that reset edge, fsm_busy, mem_ren, write_data_array and write_tag_array SHALL be 0, and memory_address, fill_word and fill_data SHALL be 0 while idle.
REQ-032 A reset during FILL SHALL abandon the fill with no tag write; in-flight responses after reset SHALL be ignored.

Verification
REQ-033 Miss at 0x1236, mem_grant=1 constantly, 4-cycle memory (miss at cycle 0):
- mem_ren cycles 1-8, addresses 0x1230,0x1232..0x123E;
- write_data_array cycles 5-12, fill_word 0..7;
- write_tag_array cycle 12 only; fsm_busy 1 in cycles 0-12, 0 in cycle 13.
REQ-034 Same miss with mem_grant=0 in cycles 2-3:
- address 0x1232 held in cycles 2-4;
- last request in cycle 10; write_tag_array in cycle 14.
REQ-035 Miss at 0xFFFE -> addresses 0xFFF0..0xFFFE, no wrap into 0x0000.
REQ-036 Inputs: miss_detected pulse during FILL, and memory_data_valid while in IDLE -> base unchanged, no extra data-array or tag writes.
REQ-037 rst=1 after the third returned word -> next cycle all outputs 0, no write_tag_array; a following miss at 0x0040 fills 0x0040..0x004E normally.
REQ-038 Back-to-back misses 0x0100 then 0x0200 (second presented the cycle after the first tag write) -> 8+8 data writes, 2 tag pulses, fsm_busy continuous.
